axi_stream_checker: RTL and testbench

- AXI-Stream sink that receives one packet of NUM_BEATS beats and checks each beat against the expected incrementing pattern BASE+i.
- Reports a pass/fail verdict, error count and first failing index in hardware, replacing post-run buffer inspection.
- Sits at the receive end of an axi_stream_if link, opposite a pattern-generating master.

---
 rtl/axi_stream_pkg.sv | 18 +
 rtl/axi_stream_ready_gen.sv | 29 ++
 rtl/axi_stream_checker.sv | 132 +++++++++++++
 tb/tb_axi_stream_checker.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_stream_pkg.sv
// Shared types and constants for the AXI-Stream pattern checker.
// The optional LFSR backpressure (AXI_STREAM_CHECK_BACKPRESSURE_EN) uses LFSR_TAPS.
package axi_stream_pkg;

  localparam int AXIS_DATA_WIDTH = 32;

  typedef logic [AXIS_DATA_WIDTH-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } checker_state_e;

  // Fibonacci taps 8,6,5,4 expressed as a mask over bits [7:0]
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/axi_stream_ready_gen.sv
// Pseudo-random ready generator: bit0 of an 8-bit Fibonacci LFSR.
// Only instantiated when AXI_STREAM_CHECK_BACKPRESSURE_EN is defined.
module axi_stream_ready_gen
  import axi_stream_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic aclk,
  input  logic areset,
  input  logic load,
  input  logic enable,
  output logic ready
);

  logic [7:0] lfsr_q;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      lfsr_q <= SEED;
    end else if (load) begin
      lfsr_q <= SEED;
    end else if (enable) begin
      lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  assign ready = lfsr_q[0];

endmodule

// File: rtl/axi_stream_checker.sv
// AXI-Stream sink that checks one packet against BASE+i and reports a verdict.
// Define AXI_STREAM_CHECK_BACKPRESSURE_EN to gate s_tready with an LFSR.
module axi_stream_checker
  import axi_stream_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_BEATS  = 8,
  parameter logic [DATA_WIDTH-1:0] BASE       = 32'hdeadbeef,
  parameter logic [7:0]            LFSR_SEED  = 8'hA5
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic                           start,
  input  logic [DATA_WIDTH-1:0]          s_tdata,
  input  logic                           s_tvalid,
  output logic                           s_tready,
  input  logic                           s_tlast,
  output logic                           done,
  output logic                           pass,
  output logic [$clog2(NUM_BEATS+1)-1:0] err_count,
  output logic [$clog2(NUM_BEATS+1)-1:0] first_err_idx,
  output logic [$clog2(NUM_BEATS+1)-1:0] beat_count
);

  localparam int CW = $clog2(NUM_BEATS+1);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t NO_ERR_IDX = cnt_t'(NUM_BEATS);
  localparam cnt_t LAST_IDX   = cnt_t'(NUM_BEATS-1);

  checker_state_e        state_q;
  logic                  tready_q;
  logic                  done_q;
  logic                  pass_q;
  cnt_t                  errCount_q;
  cnt_t                  firstErr_q;
  cnt_t                  beatCount_q;

  logic                  readyGate;
  logic                  accept;
  logic                  isLastIdx;
  logic                  beatBad;
  logic [DATA_WIDTH-1:0] expectedData;

`ifdef AXI_STREAM_CHECK_BACKPRESSURE_EN
  logic lfsrLoad;
  logic lfsrEnable;

  // Start is ignored mid-run, so it only reseeds the LFSR outside RECV
  assign lfsrLoad   = start && (state_q != RECV);
  assign lfsrEnable = (state_q == RECV);

  axi_stream_ready_gen #(
    .SEED (LFSR_SEED)
  ) u_ready_gen (
    .aclk   (aclk),
    .areset (areset),
    .load   (lfsrLoad),
    .enable (lfsrEnable),
    .ready  (readyGate)
  );
`else
  logic [7:0] unusedSeed;

  assign unusedSeed = LFSR_SEED;
  assign readyGate  = 1'b1;
`endif

  assign s_tready = tready_q & readyGate;

  always_comb begin
    expectedData = BASE + DATA_WIDTH'(beatCount_q);
    isLastIdx    = (beatCount_q == LAST_IDX);
    accept       = s_tvalid && s_tready;
    beatBad      = (s_tdata != expectedData) || (s_tlast != isLastIdx);
  end

  // A run ends on the final index or on an early tlast; pass is decided on
  // that last beat so the verdict is valid in the same cycle done rises.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= IDLE;
      tready_q    <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      errCount_q  <= '0;
      firstErr_q  <= NO_ERR_IDX;
      beatCount_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q     <= RECV;
            tready_q    <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            errCount_q  <= '0;
            firstErr_q  <= NO_ERR_IDX;
            beatCount_q <= '0;
          end
        end
        RECV: begin
          if (accept) begin
            beatCount_q <= beatCount_q + cnt_t'(1);
            if (beatBad) begin
              errCount_q <= errCount_q + cnt_t'(1);
              if (errCount_q == '0) begin
                firstErr_q <= beatCount_q;
              end
            end
            if (isLastIdx || s_tlast) begin
              state_q  <= DONE;
              tready_q <= 1'b0;
              done_q   <= 1'b1;
              pass_q   <= !beatBad && (errCount_q == '0) && isLastIdx;
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          tready_q <= 1'b0;
        end
      endcase
    end
  end

  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = errCount_q;
  assign first_err_idx = firstErr_q;
  assign beat_count    = beatCount_q;

endmodule

// File: tb/tb_axi_stream_checker.sv
// Randomized self-checking bench: two checkers (default BASE and a wrapping
// BASE) watch the same stream and are compared against a packet-level model.
module tb_axi_stream_checker;

  localparam int          N         = 8;
  localparam int          CW        = $clog2(N+1);
  localparam logic [31:0] BASE_A    = 32'hdeadbeef;
  localparam logic [31:0] BASE_WRAP = 32'hfffffffe;

  logic          aclk = 1'b0;
  logic          areset;
  logic          start;
  logic [31:0]   sTdata;
  logic          sTvalid;
  logic          sTlast;

  logic          sTready, done, pass;
  logic [CW-1:0] errCount, firstErr, beatCount;
  logic          wTready, wDone, wPass;
  logic [CW-1:0] wErrCount, wFirstErr, wBeatCount;

  int checkCount = 0;
  int errorCount = 0;
  int cycleCount = 0;
  int startCycle = 0;

  logic [31:0] pktData [N];
  logic        pktLast [N];

  axi_stream_checker #(
    .DATA_WIDTH (32),
    .NUM_BEATS  (N),
    .BASE       (BASE_A),
    .LFSR_SEED  (8'hA5)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .start         (start),
    .s_tdata       (sTdata),
    .s_tvalid      (sTvalid),
    .s_tready      (sTready),
    .s_tlast       (sTlast),
    .done          (done),
    .pass          (pass),
    .err_count     (errCount),
    .first_err_idx (firstErr),
    .beat_count    (beatCount)
  );

  axi_stream_checker #(
    .DATA_WIDTH (32),
    .NUM_BEATS  (N),
    .BASE       (BASE_WRAP),
    .LFSR_SEED  (8'hA5)
  ) dutWrap (
    .aclk          (aclk),
    .areset        (areset),
    .start         (start),
    .s_tdata       (sTdata),
    .s_tvalid      (sTvalid),
    .s_tready      (wTready),
    .s_tlast       (sTlast),
    .done          (wDone),
    .pass          (wPass),
    .err_count     (wErrCount),
    .first_err_idx (wFirstErr),
    .beat_count    (wBeatCount)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Packet-level reference: walk the beats as the master sent them.
  task automatic modelRun(input logic [31:0] base, output int len, output int errs,
                          output int first, output bit ok);
    logic [31:0] expWord;
    errs  = 0;
    first = N;
    len   = 0;
    for (int i = 0; i < N; i++) begin
      expWord = base + 32'(i);
      len++;
      if (pktData[i] != expWord || pktLast[i] != (i == N-1)) begin
        errs++;
        if (first == N) first = i;
      end
      if (pktLast[i]) break;
    end
    ok = (errs == 0) && (len == N);
  endtask

  task automatic buildPacket(input int kind, input logic [31:0] base);
    int idx;
    for (int i = 0; i < N; i++) begin
      pktData[i] = base + 32'(i);
      pktLast[i] = (i == N-1);
    end
    idx = int'($urandom_range(0, N-1));
    case (kind)
      1: pktData[idx] = $urandom();
      2: begin
        idx = int'($urandom_range(0, N-2));
        pktLast[idx] = 1'b1;
      end
      3: pktLast[N-1] = 1'b0;
      4: begin
        for (int i = 0; i < N; i++) begin
          if ($urandom_range(0, 2) == 0) pktData[i] = $urandom();
          pktLast[i] = ($urandom_range(0, 5) == 0) || (i == N-1);
        end
      end
      default: ;
    endcase
  endtask

  task automatic checkResetState();
    checkOutput("rstDone", done, 0);
    checkOutput("rstPass", pass, 0);
    checkOutput("rstErrCount", errCount, 0);
    checkOutput("rstBeatCount", beatCount, 0);
    checkOutput("rstFirstErr", firstErr, N);
    checkOutput("rstReady", sTready, 0);
    checkOutput("rstWrapReady", wTready, 0);
  endtask

  task automatic checkVerdict();
    int len, errs, first;
    bit ok;
    modelRun(BASE_A, len, errs, first, ok);
    checkOutput("done", done, 1);
    checkOutput("pass", pass, ok);
    checkOutput("errCount", errCount, errs);
    checkOutput("firstErr", firstErr, first);
    checkOutput("beatCount", beatCount, len);
    checkOutput("readyInDone", sTready, 0);
    modelRun(BASE_WRAP, len, errs, first, ok);
    checkOutput("wDone", wDone, 1);
    checkOutput("wPass", wPass, ok);
    checkOutput("wErrCount", wErrCount, errs);
    checkOutput("wFirstErr", wFirstErr, first);
    checkOutput("wBeatCount", wBeatCount, len);
  endtask

  task automatic applyStimulus(input int len, input bit gaps, input int midStartIdx,
                               input bit waitDone, output int latency);
    int guard;
    bit hs;
    bit timedOut;
    latency  = 0;
    timedOut = 0;
    @(negedge aclk);
    start      = 1'b1;
    startCycle = cycleCount;
    @(negedge aclk);
    start = 1'b0;
    for (int i = 0; i < len && !timedOut; i++) begin
      if (i == midStartIdx) begin
        sTvalid = 1'b0;
        start   = 1'b1;
        @(negedge aclk);
        start = 1'b0;
      end else if (gaps && $urandom_range(0, 3) == 0) begin
        sTvalid = 1'b0;
        @(negedge aclk);
      end
      sTdata  = pktData[i];
      sTlast  = pktLast[i];
      sTvalid = 1'b1;
      guard   = 0;
      hs      = 1'b0;
      while (!hs && !timedOut) begin
        hs = sTready;
        @(negedge aclk);
        guard++;
        if (!hs && guard > 300) begin
          timedOut = 1'b1;
          checkOutput("handshakeTimeout", 0, 1);
        end
      end
    end
    sTvalid = 1'b0;
    sTlast  = 1'b0;
    if (waitDone && !timedOut) begin
      guard = 0;
      while (!done && guard < 20) begin
        @(negedge aclk);
        guard++;
      end
      checkOutput("doneTimeout", done, 1);
      latency = cycleCount - startCycle;
    end
  endtask

  task automatic runCase(input bit gaps, input int midStartIdx, output int latency);
    int len, errs, first;
    bit ok;
    modelRun(BASE_A, len, errs, first, ok);
    applyStimulus(len, gaps, midStartIdx, 1'b1, latency);
    checkVerdict();
  endtask

  initial begin
    int lat;
    areset  = 1'b1;
    start   = 1'b0;
    sTdata  = '0;
    sTvalid = 1'b0;
    sTlast  = 1'b0;
    repeat (3) @(negedge aclk);
    checkResetState();
    areset = 1'b0;

    // Valid while idle must not count as a beat
    sTdata  = BASE_A;
    sTvalid = 1'b1;
    repeat (3) @(negedge aclk);
    checkOutput("idleBeatCount", beatCount, 0);
    checkOutput("idleReady", sTready, 0);
    checkOutput("idleDone", done, 0);
    sTvalid = 1'b0;

    buildPacket(0, BASE_A);
    runCase(1'b0, -1, lat);
`ifdef AXI_STREAM_CHECK_BACKPRESSURE_EN
    checkOutput("latencyAbove9", lat > 9, 1);
`else
    checkOutput("latency", lat, 9);
`endif
    checkOutput("cleanPass", pass, 1);

    buildPacket(0, BASE_A);
    pktData[3] = 32'h0;
    runCase(1'b0, -1, lat);
    checkOutput("corruptFirstErr", firstErr, 3);

    buildPacket(0, BASE_A);
    pktLast[5] = 1'b1;
    runCase(1'b0, -1, lat);
    checkOutput("shortBeatCount", beatCount, 6);

    buildPacket(0, BASE_WRAP);
    runCase(1'b0, -1, lat);
    checkOutput("wrapPass", wPass, 1);

    buildPacket(0, BASE_A);
    runCase(1'b0, 3, lat);

    // Abandon a run after four beats, then recover with a clean packet
    buildPacket(0, BASE_A);
    applyStimulus(4, 1'b0, -1, 1'b0, lat);
    areset = 1'b1;
    #1;
    checkResetState();
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    checkOutput("postResetReady", sTready, 0);
    runCase(1'b0, -1, lat);
    checkOutput("postResetPass", pass, 1);

    for (int p = 0; p < 40; p++) begin
      buildPacket(int'($urandom_range(0, 4)), ($urandom_range(0, 1) == 0) ? BASE_A : BASE_WRAP);
      runCase(1'b1, -1, lat);
      repeat (int'($urandom_range(0, 3))) @(negedge aclk);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
